// File: rtl/pipeline_hold_ctrl_if.sv
// Pipeline hold/flush interface bundle.
// Groups the hazard-unit requests, the fetch/decode data flowing into the
// pipeline registers, and the registered pipeline/status outputs.
//   master : hazard/branch logic and the fetch/decode stages (drive requests and data)
//   slave  : pipeline_hold_ctrl (owns PC, IF/ID, ID/EX control and counters)
interface pipeline_hold_ctrl_if #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  // requests and incoming data
  logic              PCWrite;
  logic              IFIDWrite;
  logic              BubbleSel;
  logic              Flush;
  logic [31:0]       PCNext;
  logic [31:0]       InstrF;
  logic [31:0]       PCPlus4F;
  logic [CTRL_W-1:0] CtrlD;
  // registered results
  logic [31:0]       PC;
  logic [31:0]       InstrD;
  logic [31:0]       PCPlus4D;
  logic [CTRL_W-1:0] CtrlE;
  logic              StallActive;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;
  logic              StallTimeout;

  modport master (
    output PCWrite, IFIDWrite, BubbleSel, Flush, PCNext, InstrF, PCPlus4F, CtrlD,
    input  PC, InstrD, PCPlus4D, CtrlE, StallActive, StallCount, FlushCount, StallTimeout
  );

  modport slave (
    input  PCWrite, IFIDWrite, BubbleSel, Flush, PCNext, InstrF, PCPlus4F, CtrlD,
    output PC, InstrD, PCPlus4D, CtrlE, StallActive, StallCount, FlushCount, StallTimeout
  );
endinterface

// File: rtl/pipeline_hold_ctrl.sv
// pipeline_hold_ctrl
// Responder side of the load-use stall interface. Owns the PC register, the
// IF/ID register and the ID/EX control register; applies stall/bubble
// requests and branch flushes, tracks RUN/STALL/FLUSH state, keeps saturating
// stall/flush counters and a watchdog that forces one advance after
// MAX_STALL consecutive stall edges.
// Ports:
//   Clk    in  pipeline clock, rising edge
//   Rst_n  in  asynchronous active-low reset
//   bus    slave modport of pipeline_hold_ctrl_if (requests in, registers out)
module pipeline_hold_ctrl #(
  parameter int          CTRL_W    = 8,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic                Clk,
  input logic                Rst_n,
  pipeline_hold_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam int CONSEC_W = $clog2(MAX_STALL + 1);
  localparam logic [CONSEC_W-1:0] WD_LIMIT = CONSEC_W'(MAX_STALL - 1);

  state_t              state_reg, state_next;
  logic [CONSEC_W-1:0] consec_reg;
  logic [31:0]         pc_reg, instr_reg, pcplus4_reg;
  logic [CTRL_W-1:0]   ctrl_reg;
  logic                stall_active_reg, timeout_reg;
  logic [CNT_W-1:0]    stall_cnt_reg, flush_cnt_reg;

  logic stall_req, watchdog, stall_taken;

  // Event priority: Flush > watchdog release > stall_req > normal.
  // The watchdog can only fire from STALL, where consec counts the run so far.
  always_comb begin
    stall_req   = ~bus.PCWrite;
    watchdog    = (state_reg == STALL) && stall_req && !bus.Flush &&
                  (consec_reg == WD_LIMIT);
    stall_taken = stall_req && !bus.Flush && !watchdog;
    state_next  = RUN;
    if (bus.Flush)        state_next = FLUSH;
    else if (watchdog)    state_next = RUN;
    else if (stall_req)   state_next = STALL;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg        <= RUN;
      consec_reg       <= '0;
      pc_reg           <= RESET_PC;
      instr_reg        <= '0;
      pcplus4_reg      <= '0;
      ctrl_reg         <= '0;
      stall_active_reg <= 1'b0;
      timeout_reg      <= 1'b0;
      stall_cnt_reg    <= '0;
      flush_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      stall_active_reg <= (state_next == STALL);

      // consec only survives across consecutive honoured stall edges
      if (stall_taken) consec_reg <= consec_reg + 1'b1;
      else             consec_reg <= '0;

      if (bus.Flush || watchdog || bus.PCWrite)
        pc_reg <= bus.PCNext;

      // Flush squashes IF/ID to a NOP regardless of IFIDWrite
      if (bus.Flush) begin
        instr_reg   <= '0;
        pcplus4_reg <= '0;
      end else if (bus.IFIDWrite || watchdog) begin
        instr_reg   <= bus.InstrF;
        pcplus4_reg <= bus.PCPlus4F;
      end

      ctrl_reg <= bus.BubbleSel ? '0 : bus.CtrlD;

      if (watchdog) timeout_reg <= 1'b1;

      if (stall_taken && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (bus.Flush && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.PC           = pc_reg;
  assign bus.InstrD       = instr_reg;
  assign bus.PCPlus4D     = pcplus4_reg;
  assign bus.CtrlE        = ctrl_reg;
  assign bus.StallActive  = stall_active_reg;
  assign bus.StallCount   = stall_cnt_reg;
  assign bus.FlushCount   = flush_cnt_reg;
  assign bus.StallTimeout = timeout_reg;

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// Directed bench for pipeline_hold_ctrl: each stimulus step pushes its
// hand-computed post-edge register image into a queue; an independent monitor
// pops and compares one image after every rising edge (or on demand for the
// asynchronous reset checks).
module tb_pipeline_hold_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic [7:0]  ctrl;
    logic        sa;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic        to;
  } exp_t;

  logic Clk;
  logic Rst_n;
  pipeline_hold_ctrl_if #(.CTRL_W(8), .CNT_W(4)) bus ();

  pipeline_hold_ctrl #(.CTRL_W(8), .CNT_W(4), .MAX_STALL(4), .RESET_PC(32'h0)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t  exp_q[$];
  string nm_q[$];
  event  chk_ev;
  int    checks = 0;
  int    passed = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] p4, input logic [7:0] ctrl,
                              input logic sa, input logic [3:0] sc,
                              input logic [3:0] fc, input logic to);
    exp_t e;
    e.pc = pc; e.instr = instr; e.p4 = p4; e.ctrl = ctrl;
    e.sa = sa; e.sc = sc; e.fc = fc; e.to = to;
    return e;
  endfunction

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req)
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, req);
    else
      passed++;
  endtask

  // monitor: one comparison set per edge (or per reset probe)
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge Clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        chk(nm, "PC",           bus.PC,                   e.pc);
        chk(nm, "InstrD",       bus.InstrD,               e.instr);
        chk(nm, "PCPlus4D",     bus.PCPlus4D,             e.p4);
        chk(nm, "CtrlE",        32'(bus.CtrlE),           32'(e.ctrl));
        chk(nm, "StallActive",  32'(bus.StallActive),     32'(e.sa));
        chk(nm, "StallCount",   32'(bus.StallCount),      32'(e.sc));
        chk(nm, "FlushCount",   32'(bus.FlushCount),      32'(e.fc));
        chk(nm, "StallTimeout", 32'(bus.StallTimeout),    32'(e.to));
        $display("chk %-10s PC=%h InstrD=%h CtrlE=%h SA=%0d SC=%0d FC=%0d TO=%0d",
                 nm, bus.PC, bus.InstrD, bus.CtrlE, bus.StallActive,
                 bus.StallCount, bus.FlushCount, bus.StallTimeout);
      end
    end
  end

  task automatic drive(input string nm, input logic pcw, input logic ifw,
                       input logic bub, input logic fl, input logic [31:0] pcn,
                       input logic [31:0] ins, input logic [31:0] p4,
                       input logic [7:0] ctl, input exp_t e);
    bus.PCWrite   = pcw;
    bus.IFIDWrite = ifw;
    bus.BubbleSel = bub;
    bus.Flush     = fl;
    bus.PCNext    = pcn;
    bus.InstrF    = ins;
    bus.PCPlus4F  = p4;
    bus.CtrlD     = ctl;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic step(input string nm, input logic pcw, input logic ifw,
                      input logic bub, input logic fl, input logic [31:0] pcn,
                      input logic [31:0] ins, input logic [31:0] p4,
                      input logic [7:0] ctl, input exp_t e);
    @(negedge Clk);
    #1;
    drive(nm, pcw, ifw, bub, fl, pcn, ins, p4, ctl, e);
  endtask

  task automatic reset_probe(input string nm);
    exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 8'h0, 1'b0, 4'd0, 4'd0, 1'b0));
    nm_q.push_back(nm);
    ->chk_ev;
    #2;
  endtask

  // global time bound
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time bound expired");
  end

  initial begin
    bus.PCWrite = 1'b1; bus.IFIDWrite = 1'b1; bus.BubbleSel = 1'b0; bus.Flush = 1'b0;
    bus.PCNext = '0; bus.InstrF = '0; bus.PCPlus4F = '0; bus.CtrlD = '0;
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #1 reset_probe("reset");

    // release reset together with the first normal fetch
    @(negedge Clk); #1;
    Rst_n = 1'b1;
    drive("run1", 1, 1, 0, 0, 32'h4, 32'hA1, 32'h4, 8'h11,
          mk(32'h4, 32'hA1, 32'h4, 8'h11, 0, 4'd0, 4'd0, 0));
    step("run2", 1, 1, 0, 0, 32'h8, 32'hA2, 32'h8, 8'h22,
         mk(32'h8, 32'hA2, 32'h8, 8'h22, 0, 4'd0, 4'd0, 0));
    // load-use stall with bubble
    step("loaduse", 0, 0, 1, 0, 32'hC, 32'hA3, 32'hC, 8'h33,
         mk(32'h8, 32'hA2, 32'h8, 8'h00, 1, 4'd1, 4'd0, 0));
    step("resume", 1, 1, 0, 0, 32'hC, 32'hA3, 32'hC, 8'h33,
         mk(32'hC, 32'hA3, 32'hC, 8'h33, 0, 4'd1, 4'd0, 0));
    // PC advances, IF/ID holds
    step("ifidhold", 1, 0, 0, 0, 32'h10, 32'hA4, 32'h10, 8'h44,
         mk(32'h10, 32'hA3, 32'hC, 8'h44, 0, 4'd1, 4'd0, 0));
    // flush and stall on the same edge: flush wins
    step("flushstl", 0, 0, 0, 1, 32'h40, 32'hA5, 32'h14, 8'h55,
         mk(32'h40, 32'h0, 32'h0, 8'h55, 0, 4'd1, 4'd1, 0));
    step("postfl", 1, 1, 0, 0, 32'h44, 32'hB1, 32'h44, 8'h66,
         mk(32'h44, 32'hB1, 32'h44, 8'h66, 0, 4'd1, 4'd1, 0));
    // watchdog: 3 held edges, 4th forces advance, then stalls resume
    step("wd_s1", 0, 0, 0, 0, 32'h48, 32'hB2, 32'h48, 8'h77,
         mk(32'h44, 32'hB1, 32'h44, 8'h77, 1, 4'd2, 4'd1, 0));
    step("wd_s2", 0, 0, 0, 0, 32'h48, 32'hB2, 32'h48, 8'h77,
         mk(32'h44, 32'hB1, 32'h44, 8'h77, 1, 4'd3, 4'd1, 0));
    step("wd_s3", 0, 0, 0, 0, 32'h48, 32'hB2, 32'h48, 8'h77,
         mk(32'h44, 32'hB1, 32'h44, 8'h77, 1, 4'd4, 4'd1, 0));
    step("wd_fire", 0, 0, 0, 0, 32'h48, 32'hB2, 32'h48, 8'h77,
         mk(32'h48, 32'hB2, 32'h48, 8'h77, 0, 4'd4, 4'd1, 1));
    step("wd_s5", 0, 0, 0, 0, 32'h4C, 32'hB3, 32'h4C, 8'h77,
         mk(32'h48, 32'hB2, 32'h48, 8'h77, 1, 4'd5, 4'd1, 1));
    step("wd_s6", 0, 0, 0, 0, 32'h4C, 32'hB3, 32'h4C, 8'h77,
         mk(32'h48, 32'hB2, 32'h48, 8'h77, 1, 4'd6, 4'd1, 1));
    step("wd_rel", 1, 1, 0, 0, 32'h50, 32'hB4, 32'h50, 8'h88,
         mk(32'h50, 32'hB4, 32'h50, 8'h88, 0, 4'd6, 4'd1, 1));
    // flush counter saturates at 4'hF
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] fc_exp;
      fc_exp = (1 + k > 15) ? 4'hF : 4'(1 + k);
      step("sat", 1, 1, 0, 1, 32'h60, 32'hC1, 32'h60, 8'h99,
           mk(32'h60, 32'h0, 32'h0, 8'h99, 0, 4'd6, fc_exp, 1));
    end
    // FLUSH -> STALL, then reset in the middle of the stall
    step("fl2stall", 0, 0, 0, 0, 32'h70, 32'hC2, 32'h70, 8'hAA,
         mk(32'h60, 32'h0, 32'h0, 8'hAA, 1, 4'd7, 4'hF, 1));
    @(negedge Clk); #1;
    Rst_n = 1'b0;
    reset_probe("rst_mid");
    @(negedge Clk); #1;
    Rst_n = 1'b1;
    drive("rel_run", 1, 1, 0, 0, 32'h4, 32'hD1, 32'h4, 8'hBB,
          mk(32'h4, 32'hD1, 32'h4, 8'hBB, 0, 4'd0, 4'd0, 0));
    // no residual stall run: watchdog needs a fresh run of 4 stall edges
    step("rs_s1", 0, 0, 0, 0, 32'h8, 32'hD2, 32'h8, 8'hBB,
         mk(32'h4, 32'hD1, 32'h4, 8'hBB, 1, 4'd1, 4'd0, 0));
    step("rs_s2", 0, 0, 0, 0, 32'h8, 32'hD2, 32'h8, 8'hBB,
         mk(32'h4, 32'hD1, 32'h4, 8'hBB, 1, 4'd2, 4'd0, 0));
    step("rs_s3", 0, 0, 0, 0, 32'h8, 32'hD2, 32'h8, 8'hBB,
         mk(32'h4, 32'hD1, 32'h4, 8'hBB, 1, 4'd3, 4'd0, 0));
    step("rs_fire", 0, 0, 0, 0, 32'h8, 32'hD2, 32'h8, 8'hBB,
         mk(32'h8, 32'hD2, 32'h8, 8'hBB, 0, 4'd3, 4'd0, 1));

    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
